// File: rtl/bsg_mesh_router_pkg.sv
// Shared types and constants for the mesh router output arbiter.
//   mesh_arb_state_e     : arbiter FSM state (idle or locked to a packet owner)
//   mesh_arb_max_len_gp  : largest body-flit count a default 4-bit length field can hold
package bsg_mesh_router_pkg;

    typedef enum logic {eArbIdle, eArbLock} mesh_arb_state_e;

    localparam int mesh_arb_max_len_gp = 15;

endpackage

// File: rtl/bsg_mesh_router_rr_picker.sv
// Combinational round-robin picker.
// Finds the first set request starting at rr_ptr_i and wrapping modulo num_in_p.
//   v_i          in   num_in_p   request vector
//   rr_ptr_i     in   idx_w_p    search start index (always < num_in_p)
//   winner_oh_o  out  num_in_p   one-hot winner, all zero when there is no request
//   winner_idx_o out  idx_w_p    encoded winner index, 0 when there is no request
module bsg_mesh_router_rr_picker
    import bsg_mesh_router_pkg::*;
#(
    parameter int num_in_p = 5,
    parameter int idx_w_p  = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic [num_in_p-1:0] v_i,
    input  logic [idx_w_p-1:0]  rr_ptr_i,
    output logic [num_in_p-1:0] winner_oh_o,
    output logic [idx_w_p-1:0]  winner_idx_o
);

    // Walk the offsets from farthest to nearest so the nearest request to the
    // pointer is the last one written and therefore wins.
    always_comb begin
        int k;
        k            = 0;
        winner_oh_o  = '0;
        winner_idx_o = '0;
        for (int off = num_in_p - 1; off >= 0; off--) begin
            k = int'(rr_ptr_i) + off;
            if (k >= num_in_p) k = k - num_in_p;
            if (v_i[k]) begin
                winner_oh_o    = '0;
                winner_oh_o[k] = 1'b1;
                winner_idx_o   = idx_w_p'(k);
            end
        end
    end

endmodule

// File: rtl/bsg_mesh_router_output_arbiter_wh.sv
// Per-output-port wormhole arbiter: round-robin head grant, packet lock until
// the last body flit has left, and credit-gated flit transfer.
// Optional feature macro: BSG_MESH_ROUTER_ARB_STALL_CNT_EN (adds stall_cnt_o).
//   clk_i        in   1                     clock
//   reset_n_i    in   1                     synchronous reset, active-low
//   v_i          in   num_in_p              per-input flit valid for this output
//   len_i        in   num_in_p*len_width_p  per-input body-flit count (used on head grant)
//   grant_o      out  num_in_p              one-hot owner / current winner
//   yumi_o       out  num_in_p              one-hot flit consumed this cycle
//   v_o          out  1                     flit sent on the output link
//   credit_i     in   1                     downstream freed one slot
//   locked_o     out  1                     output reserved mid-packet
//   stall_cnt_o  out  32                    (macro only) cycles with requests but no send
module bsg_mesh_router_output_arbiter_wh
    import bsg_mesh_router_pkg::*;
#(
    parameter int num_in_p    = 5,
    parameter int len_width_p = 4,
    parameter int credits_p   = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [num_in_p-1:0]           v_i,
    input  logic [num_in_p*len_width_p-1:0] len_i,
    output logic [num_in_p-1:0]           grant_o,
    output logic [num_in_p-1:0]           yumi_o,
    output logic                          v_o,
    input  logic                          credit_i,
    output logic                          locked_o
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
    ,output logic [31:0]                  stall_cnt_o
`endif
);

    localparam int idx_w_lp  = (num_in_p > 1) ? $clog2(num_in_p) : 1;
    localparam int cred_w_lp = $clog2(credits_p + 1);

    mesh_arb_state_e        state_q, state_d;
    logic [idx_w_lp-1:0]    rr_ptr_q, rr_ptr_d;
    logic [idx_w_lp-1:0]    owner_q, owner_d;
    logic [len_width_p-1:0] body_cnt_q, body_cnt_d;
    logic [cred_w_lp-1:0]   credits_q, credits_d;

    logic [num_in_p-1:0]    win_oh;
    logic [idx_w_lp-1:0]    win_idx;
    logic [num_in_p-1:0]    owner_oh;
    logic [len_width_p-1:0] win_len;
    logic                   can_send;

    bsg_mesh_router_rr_picker #(
        .num_in_p (num_in_p),
        .idx_w_p  (idx_w_lp)
    ) picker (
        .v_i          (v_i),
        .rr_ptr_i     (rr_ptr_q),
        .winner_oh_o  (win_oh),
        .winner_idx_o (win_idx)
    );

    always_comb begin
        for (int i = 0; i < num_in_p; i++) begin
            owner_oh[i] = (int'(owner_q) == i);
        end
    end

    assign win_len  = len_i[int'(win_idx)*len_width_p +: len_width_p];
    assign can_send = (credits_q != '0);

    // Outputs are forced low while reset is held so nothing leaks mid-reset.
    always_comb begin
        grant_o = '0;
        if (reset_n_i) begin
            grant_o = (state_q == eArbLock) ? owner_oh : win_oh;
        end
        yumi_o   = grant_o & v_i & {num_in_p{can_send}};
        v_o      = |yumi_o;
        locked_o = reset_n_i & (state_q == eArbLock);
    end

    always_comb begin
        int nxt;
        nxt        = int'(win_idx) + 1;
        if (nxt >= num_in_p) nxt = 0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        body_cnt_d = body_cnt_q;
        credits_d  = credits_q;

        case (state_q)
            eArbIdle: begin
                if (v_o) begin
                    // Pointer moves only once the head actually leaves.
                    rr_ptr_d = idx_w_lp'(nxt);
                    if (win_len != '0) begin
                        body_cnt_d = win_len;
                        owner_d    = win_idx;
                        state_d    = eArbLock;
                    end
                end
            end
            eArbLock: begin
                if (v_o) begin
                    body_cnt_d = body_cnt_q - len_width_p'(1);
                    if (body_cnt_q == len_width_p'(1)) state_d = eArbIdle;
                end
            end
            default: state_d = eArbIdle;
        endcase

        if (v_o && !credit_i) begin
            credits_d = credits_q - cred_w_lp'(1);
        end else if (credit_i && !v_o && (credits_q != cred_w_lp'(credits_p))) begin
            credits_d = credits_q + cred_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= eArbIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            body_cnt_q <= '0;
            credits_q  <= cred_w_lp'(credits_p);
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            body_cnt_q <= body_cnt_d;
            credits_q  <= credits_d;
        end
    end

`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stall_cnt_q <= '0;
        end else if ((|v_i) && !v_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ($onehot0(grant_o)) else $fatal(1, "grant_o not one-hot");
            assert ($onehot0(yumi_o))  else $fatal(1, "yumi_o not one-hot");
            assert (!v_o || can_send)  else $fatal(1, "v_o without credit");
            assert (!(credit_i && (credits_q == cred_w_lp'(credits_p))))
                else $fatal(1, "credit returned while counter full");
        end
    end

endmodule

// File: tb/tb_bsg_mesh_router_output_arbiter_wh.sv
module tb_bsg_mesh_router_output_arbiter_wh;

    localparam int N  = 5;
    localparam int LW = 4;
    localparam int CR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    v;
    logic [N*LW-1:0] len;
    logic            credit;
    logic [N-1:0]    grant, yumi;
    logic            vo, locked;
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    always #5 clk = ~clk;

    bsg_mesh_router_output_arbiter_wh #(
        .num_in_p    (N),
        .len_width_p (LW),
        .credits_p   (CR)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .v_i         (v),
        .len_i       (len),
        .grant_o     (grant),
        .yumi_o      (yumi),
        .v_o         (vo),
        .credit_i    (credit),
        .locked_o    (locked)
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
        ,.stall_cnt_o (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: packet-level view (who owns the link, how many flits remain,
    // whose turn it is, how many downstream slots are free).
    bit           m_busy;
    int           m_owner, m_left, m_ptr, m_cred, m_stall;
    int           e_w;
    bit           e_send;
    logic [N-1:0] e_grant, e_yumi;
    logic         e_vo, e_locked;

    function automatic logic cr_ok();
        return (m_cred < CR) ? 1'b1 : 1'b0;
    endfunction

    task automatic model_eval();
        e_w = -1;
        e_send = 0;
        e_grant = '0;
        if (rst_n) begin
            if (m_busy) e_w = m_owner;
            else begin
                for (int off = 0; off < N; off++) begin
                    if (e_w < 0 && v[(m_ptr + off) % N]) e_w = (m_ptr + off) % N;
                end
            end
            if (e_w >= 0) begin
                e_grant = N'(1) << e_w;
                e_send = v[e_w] && (m_cred > 0);
            end
        end
        e_yumi   = e_send ? e_grant : '0;
        e_vo     = e_send;
        e_locked = rst_n && m_busy;
    endtask

    task automatic drive(input logic [N-1:0] vv, input logic [N*LW-1:0] ll,
                         input logic cr, input logic rn);
        v = vv; len = ll; credit = cr; rst_n = rn;
        #1;
        model_eval();
    endtask

    task automatic tick();
        int l;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_cred = CR; m_stall = 0;
        end else begin
            if ((|v) && !e_send) m_stall++;
            if (e_send) begin
                if (!m_busy) begin
                    m_ptr = (e_w + 1) % N;
                    l = int'(len[e_w*LW +: LW]);
                    if (l > 0) begin m_busy = 1; m_owner = e_w; m_left = l; end
                end else begin
                    m_left--;
                    if (m_left == 0) m_busy = 0;
                end
            end
            m_cred = m_cred + int'(credit) - int'(e_send);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b0, 1'b0); tick();
        drive('0, '0, 1'b0, 1'b0); tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive('1, '1, 1'b0, 1'b0);
            n_cmp++;
            if ({grant, yumi, vo, locked} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc %0d: got g=%b y=%b v=%b l=%b want all zero",
                         c, grant, yumi, vo, locked);
            end
            tick();
        end
    endtask

    task automatic test_rr_single();
        int exp_idx[4] = '{0, 2, 4, 0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(5'b10101, '0, cr_ok(), 1'b1);
            n_cmp++;
            if ({grant, yumi, vo, locked} !== {e_grant, e_yumi, e_vo, e_locked}) begin
                n_bad++;
                $display("FAIL rr_model cyc %0d: got g=%b y=%b v=%b l=%b want g=%b y=%b v=%b l=%b",
                         c, grant, yumi, vo, locked, e_grant, e_yumi, e_vo, e_locked);
            end
            n_cmp++;
            if (grant !== (N'(1) << exp_idx[c]) || vo !== 1'b1) begin
                n_bad++;
                $display("FAIL rr_order cyc %0d: got g=%b v=%b want g=%b v=1",
                         c, grant, vo, N'(1) << exp_idx[c]);
            end
            tick();
        end
    endtask

    // Runs right after test_rr_single, so the pointer sits at input 1.
    task automatic test_lock();
        logic [N-1:0] exp_g[5] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b01000};
        logic         exp_l[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [N*LW-1:0] ll;
        ll = '0;
        ll[1*LW +: LW] = LW'(3);
        for (int c = 0; c < 5; c++) begin
            drive(5'b01010, ll, cr_ok(), 1'b1);
            n_cmp++;
            if ({grant, yumi, vo, locked} !== {e_grant, e_yumi, e_vo, e_locked}) begin
                n_bad++;
                $display("FAIL lock_model cyc %0d: got g=%b y=%b v=%b l=%b want g=%b y=%b v=%b l=%b",
                         c, grant, yumi, vo, locked, e_grant, e_yumi, e_vo, e_locked);
            end
            n_cmp++;
            if (grant !== exp_g[c] || locked !== exp_l[c] || vo !== 1'b1) begin
                n_bad++;
                $display("FAIL lock_seq cyc %0d: got g=%b l=%b v=%b want g=%b l=%b v=1",
                         c, grant, locked, vo, exp_g[c], exp_l[c]);
            end
            tick();
        end
    endtask

    task automatic test_credit_exhaust();
        int pulses;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 9; c++) begin
            drive('1, '0, (c == 5) ? 1'b1 : 1'b0, 1'b1);
            n_cmp++;
            if ({grant, yumi, vo, locked} !== {e_grant, e_yumi, e_vo, e_locked}) begin
                n_bad++;
                $display("FAIL credit_model cyc %0d: got g=%b y=%b v=%b l=%b want g=%b y=%b v=%b l=%b",
                         c, grant, yumi, vo, locked, e_grant, e_yumi, e_vo, e_locked);
            end
            if (vo === 1'b1) pulses++;
            if (c == 4) begin
                n_cmp++;
                if (pulses != 2 || vo !== 1'b0 || grant === '0) begin
                    n_bad++;
                    $display("FAIL credit_block: got pulses=%0d v=%b g=%b want pulses=2 v=0 g!=0",
                             pulses, vo, grant);
                end
            end
            tick();
        end
        n_cmp++;
        if (pulses != 3) begin
            n_bad++;
            $display("FAIL credit_release: got pulses=%0d want 3", pulses);
        end
    endtask

    task automatic test_same_cycle();
        logic exp_v[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic cr_s[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(5'b00001, '0, cr_s[c], 1'b1);
            n_cmp++;
            if ({grant, yumi, vo, locked} !== {e_grant, e_yumi, e_vo, e_locked}) begin
                n_bad++;
                $display("FAIL same_model cyc %0d: got g=%b y=%b v=%b l=%b want g=%b y=%b v=%b l=%b",
                         c, grant, yumi, vo, locked, e_grant, e_yumi, e_vo, e_locked);
            end
            n_cmp++;
            if (vo !== exp_v[c]) begin
                n_bad++;
                $display("FAIL same_cycle cyc %0d: got v=%b want %b", c, vo, exp_v[c]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [N*LW-1:0] ll;
        ll = '0;
        ll[0 +: LW] = LW'(3);
        do_reset();
        drive(5'b00011, ll, 1'b0, 1'b1); tick();
        drive(5'b00011, ll, 1'b0, 1'b1); tick();
        for (int c = 0; c < 2; c++) begin
            drive('1, ll, 1'b0, 1'b0);
            n_cmp++;
            if ({grant, yumi, vo, locked} !== '0) begin
                n_bad++;
                $display("FAIL midrst_outputs cyc %0d: got g=%b y=%b v=%b l=%b want all zero",
                         c, grant, yumi, vo, locked);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(5'b00011, '0, 1'b0, 1'b1);
            n_cmp++;
            if ({grant, yumi, vo, locked} !== {e_grant, e_yumi, e_vo, e_locked}) begin
                n_bad++;
                $display("FAIL midrst_model cyc %0d: got g=%b y=%b v=%b l=%b want g=%b y=%b v=%b l=%b",
                         c, grant, yumi, vo, locked, e_grant, e_yumi, e_vo, e_locked);
            end
            if (c == 0) begin
                n_cmp++;
                if (grant !== 5'b00001 || locked !== 1'b0 || vo !== 1'b1) begin
                    n_bad++;
                    $display("FAIL midrst_after: got g=%b l=%b v=%b want g=00001 l=0 v=1",
                             grant, locked, vo);
                end
            end
            tick();
        end
    endtask

`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(5'b00001, '0, 1'b0, 1'b1); tick();
        end
        n_cmp++;
        if (stall_cnt !== 32'd3) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0]    vv;
        logic [N*LW-1:0] ll;
        logic            rn;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            vv = N'($urandom);
            ll = '0;
            for (int i = 0; i < N; i++) ll[i*LW +: LW] = LW'($urandom_range(0, 3));
            rn = ($urandom_range(0, 49) != 0);
            drive(vv, ll, cr_ok() & 1'($urandom_range(0, 1)), rn);
            n_cmp++;
            if ({grant, yumi, vo, locked} !== {e_grant, e_yumi, e_vo, e_locked}) begin
                n_bad++;
                $display("FAIL random cyc %0d: got g=%b y=%b v=%b l=%b want g=%b y=%b v=%b l=%b",
                         c, grant, yumi, vo, locked, e_grant, e_yumi, e_vo, e_locked);
            end
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
            n_cmp++;
            if (stall_cnt !== 32'(m_stall)) begin
                n_bad++;
                $display("FAIL random_stall cyc %0d: got %0d want %0d", c, stall_cnt, m_stall);
            end
`endif
            tick();
        end
    endtask

    initial begin
        m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_cred = CR; m_stall = 0;
        v = '0; len = '0; credit = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_rr_single();
        test_lock();
        test_credit_exhaust();
        test_same_cycle();
        test_reset_mid();
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
